// File: rtl/counter_bus_reader_pkg.sv
// Shared types and constants for the counter bus initiator.
package counter_bus_reader_pkg;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned TIMER_W = 4;
  localparam int unsigned T_MIN   = 1;
  localparam int unsigned T_MAX   = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_HOLD = 3'd2,
    ST_TURN = 3'd3,
    ST_READ = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  // Phase lengths must fit the 4-bit phase timer and be non-zero.
  function automatic logic timing_ok(input int unsigned t);
    return (t >= T_MIN) && (t <= T_MAX);
  endfunction

endpackage

// File: rtl/counter_bus_reader_if.sv
// Host-side request/response handshake of the counter bus initiator.
interface counter_bus_reader_if
  import counter_bus_reader_pkg::*;
#(
  parameter int unsigned size = 8
) ();

  logic              start;
  logic              burst;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              valid;
  logic [ADDR_W-1:0] idx;
  logic [size-1:0]   data;
  logic              done;

  modport master (
    output start, burst, addr,
    input  busy, valid, idx, data, done
  );

  modport slave (
    input  start, burst, addr,
    output busy, valid, idx, data, done
  );

endinterface

// File: rtl/counter_bus_reader_bus_phase_timer.sv
// Down-counter timing each bus phase; terminal count marks the last cycle.
module bus_phase_timer
  import counter_bus_reader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               tc_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               tc_q, tc_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
    tc_d = (cnt_d == '0);
  end

  // Counter and registered terminal-count flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/counter_bus_reader.sv
// Read-only initiator for the multiplexed ale/rd/wr/ad counter bus.
module counter_bus_reader
  import counter_bus_reader_pkg::*;
#(
  parameter int unsigned size  = 8,
  parameter int unsigned T_ALE = 2,
  parameter int unsigned T_HOLD = 1,
  parameter int unsigned T_RD  = 3,
  parameter int unsigned T_GAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  counter_bus_reader_if.slave host,
  output logic                ale,
  output logic                rd,
  output logic                wr,
  inout  wire  [size-1:0]     ad
);

  if (!timing_ok(T_ALE))  begin : g_bad_t_ale  $error("T_ALE outside 1..15");  end
  if (!timing_ok(T_HOLD)) begin : g_bad_t_hold $error("T_HOLD outside 1..15"); end
  if (!timing_ok(T_RD))   begin : g_bad_t_rd   $error("T_RD outside 1..15");   end
  if (!timing_ok(T_GAP))  begin : g_bad_t_gap  $error("T_GAP outside 1..15");  end
  if (size < ADDR_W)      begin : g_bad_size   $error("size narrower than address"); end

  state_e             state_q, state_d;
  logic               tmr_load, tmr_tc;
  logic [TIMER_W-1:0] tmr_val;
  logic               last_word_c;

  logic [ADDR_W-1:0]  addr_q, addr_d, idx_q, idx_d;
  logic               burst_q, burst_d;
  logic               ale_q, ale_d, rd_q, rd_d, ad_oe_q, ad_oe_d;
  logic               busy_q, busy_d, valid_q, valid_d, done_q, done_d;
  logic [size-1:0]    data_q, data_d;
  logic [size-1:0]    ad_out_c;

  bus_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // A burst stops after address 3; a single read is always the last word.
  assign last_word_c = !burst_q || (&addr_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state; the phase timer is reloaded on every state change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (host.start) state_d = ST_ADDR;
      ST_ADDR: if (tmr_tc)     state_d = ST_HOLD;
      ST_HOLD: if (tmr_tc)     state_d = ST_TURN;
      ST_TURN: if (tmr_tc)     state_d = ST_READ;
      ST_READ: if (tmr_tc)     state_d = ST_GAP;
      ST_GAP:  if (tmr_tc)     state_d = last_word_c ? ST_IDLE : ST_ADDR;
      default:                 state_d = ST_IDLE;
    endcase
    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_ADDR: tmr_val = TIMER_W'(T_ALE - 32'd1);
      ST_HOLD: tmr_val = TIMER_W'(T_HOLD - 32'd1);
      ST_READ: tmr_val = TIMER_W'(T_RD - 32'd1);
      ST_GAP:  tmr_val = TIMER_W'(T_GAP - 32'd1);
      default: tmr_val = '0;
    endcase
  end

  // Output and datapath next values, decoded from the upcoming state.
  always_comb begin
    addr_d  = addr_q;
    burst_d = burst_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ale_d   = (state_d == ST_ADDR);
    rd_d    = (state_d != ST_READ);
    ad_oe_d = (state_d == ST_ADDR) || (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_q == ST_READ) && tmr_tc;
    done_d  = (state_q == ST_GAP) && tmr_tc && last_word_c;
    if ((state_q == ST_IDLE) && host.start) begin
      burst_d = host.burst;
      addr_d  = host.burst ? '0 : host.addr;
    end
    if ((state_q == ST_GAP) && (state_d == ST_ADDR)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    if (valid_d) begin
      data_d = ad;
      idx_d  = addr_q;
    end
  end

  // Registered outputs and transaction context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      burst_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      ale_q   <= 1'b0;
      rd_q    <= 1'b1;
      ad_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ale_q   <= ale_d;
      rd_q    <= rd_d;
      ad_oe_q <= ad_oe_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ad_out_c   = {{(size - ADDR_W){1'b0}}, addr_q};
  assign ad         = ad_oe_q ? ad_out_c : {size{1'bz}};
  assign ale        = ale_q;
  assign rd         = rd_q;
  assign wr         = 1'b1;
  assign host.busy  = busy_q;
  assign host.valid = valid_q;
  assign host.idx   = idx_q;
  assign host.data  = data_q;
  assign host.done  = done_q;

endmodule

// File: tb/tb_counter_bus_reader.sv
// Self-checking bench: counter responder model plus timing/protocol scoreboard.
module tb_counter_bus_reader;

  localparam int TA   = 2;
  localparam int TH   = 1;
  localparam int TR   = 3;
  localparam int TG   = 1;
  localparam int P    = TA + TH + 1 + TR + TG;
  localparam int VOFF = TA + TH + 1 + TR + 1;
  localparam int P2   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  counter_bus_reader_if #(.size(8)) hif ();
  counter_bus_reader_if #(.size(8)) hif2 ();
  wire       ale, rd, wr, ale2, rd2, wr2;
  wire [7:0] ad, ad2;

  counter_bus_reader #(.size(8), .T_ALE(TA), .T_HOLD(TH), .T_RD(TR), .T_GAP(TG)) dut (
    .clk(clk), .rst(rst), .host(hif), .ale(ale), .rd(rd), .wr(wr), .ad(ad)
  );

  counter_bus_reader #(.size(8), .T_ALE(1), .T_HOLD(1), .T_RD(1), .T_GAP(1)) dut2 (
    .clk(clk), .rst(rst), .host(hif2), .ale(ale2), .rd(rd2), .wr(wr2), .ad(ad2)
  );

  // Four free-running counters: value in a cycle = base + inc * cycle number.
  logic [7:0] base [4];
  logic [7:0] inc  [4];
  logic [1:0] r_addr = '0;
  logic       r_ale_d1 = 1'b0;
  logic [7:0] r_val = '0;

  function automatic logic [7:0] cnt_at(input logic [1:0] i, input int unsigned c);
    return 8'(32'(base[i]) + 32'(inc[i]) * c);
  endfunction

  always @(posedge clk) begin
    r_ale_d1 <= ale;
    if (ale) r_addr <= ad[1:0];
    if (r_ale_d1 && !ale) r_val <= cnt_at(r_addr, cyc);
  end
  assign ad = (!rd) ? r_val : 8'bz;

  // Responder for the minimum-timing instance: returns 0xC0 | address.
  logic [1:0] r2_addr = '0;
  always @(posedge clk) if (ale2) r2_addr <= ad2[1:0];
  assign ad2 = (!rd2) ? (8'hC0 | {6'd0, r2_addr}) : 8'bz;

  // Per-transaction observations, filled by collect().
  int          q_vcyc[$];
  logic [1:0]  q_idx[$];
  logic [7:0]  q_data[$];
  int          q_dcyc[$];
  int          q_ale[$];
  logic [1:0]  q_ale_ad[$];
  int          viol;
  int          busy_lo;
  int unsigned c0;

  task automatic kick(input logic b, input logic [1:0] a);
    @(negedge clk);
    hif.start = 1'b1; hif.burst = b; hif.addr = a;
    @(posedge clk);
    #1;
    hif.start = 1'b0; hif.burst = 1'($urandom); hif.addr = 2'($urandom);
  endtask

  task automatic collect(input int n);
    q_vcyc.delete(); q_idx.delete(); q_data.delete();
    q_dcyc.delete(); q_ale.delete(); q_ale_ad.delete();
    viol = 0; busy_lo = -1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) c0 = cyc;
      if (hif.valid) begin
        q_vcyc.push_back(c); q_idx.push_back(hif.idx); q_data.push_back(hif.data);
      end
      if (hif.done) q_dcyc.push_back(c);
      if (ale) begin q_ale.push_back(c); q_ale_ad.push_back(ad[1:0]); end
      if (!hif.busy && busy_lo < 0) busy_lo = c;
      if ((!rd && dut.ad_oe_q) || (!rd && ale) || (wr !== 1'b1) ||
          (hif.valid && hif.done) || (ale && ad[7:2] != 6'd0)) viol++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ale !== 1'b0) begin errors++; $display("FAIL reset_ale got %b want 0", ale); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL reset_rd got %b want 1", rd); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL reset_wr got %b want 1", wr); end
    checks++; if (dut.ad_oe_q !== 1'b0) begin errors++; $display("FAIL reset_ad_drive got %b want 0", dut.ad_oe_q); end
    checks++; if ({hif.busy, hif.valid, hif.done} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {hif.busy, hif.valid, hif.done}); end
    checks++; if ({hif.idx, hif.data} !== 10'd0) begin
      errors++; $display("FAIL reset_idx_data got %h/%h want 0/00", hif.idx, hif.data); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin base[i] = 8'($urandom); inc[i] = 8'd0; end
    base[2] = 8'h5A;
    kick(1'b0, 2'd2);
    collect(12);
    checks++;
    if (q_vcyc.size() != 1) begin errors++; $display("FAIL single_valid_count got %0d want 1", q_vcyc.size()); end
    else begin
      checks++; if (q_vcyc[0] != VOFF) begin errors++; $display("FAIL single_valid_cycle got %0d want %0d", q_vcyc[0], VOFF); end
      checks++; if (q_idx[0] !== 2'd2) begin errors++; $display("FAIL single_idx got %0d want 2", q_idx[0]); end
      checks++; if (q_data[0] !== 8'h5A) begin errors++; $display("FAIL single_data got %h want 5a", q_data[0]); end
    end
    checks++;
    if (q_dcyc.size() != 1 || q_dcyc[0] != P + 1) begin
      errors++; $display("FAIL single_done got %0d dones first %0d want 1 at %0d", q_dcyc.size(),
                         (q_dcyc.size() > 0) ? q_dcyc[0] : -1, P + 1); end
    checks++;
    if (q_ale.size() != TA) begin errors++; $display("FAIL single_ale_len got %0d want %0d", q_ale.size(), TA); end
    else for (int k = 0; k < TA; k++) begin
      checks++;
      if (q_ale[k] != k + 1 || q_ale_ad[k] !== 2'd2) begin
        errors++; $display("FAIL single_ale_cycle got c%0d ad %0d want c%0d ad 2", q_ale[k], q_ale_ad[k], k + 1); end
    end
    checks++; if (busy_lo != P + 1) begin errors++; $display("FAIL single_busy_fall got %0d want %0d", busy_lo, P + 1); end
    checks++; if (viol != 0) begin errors++; $display("FAIL single_protocol got %0d violations want 0", viol); end
    checks++; if (hif.data !== 8'h5A || hif.idx !== 2'd2) begin
      errors++; $display("FAIL single_hold got %h/%0d want 5a/2", hif.data, hif.idx); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 3; i++) begin base[i] = 8'($urandom); inc[i] = 8'(2 * i + 3); end
    base[3] = 8'($urandom); inc[3] = 8'd1;
    repeat (300) @(posedge clk);
    kick(1'b1, 2'($urandom));
    collect(4 * P + 4);
    checks++;
    if (q_vcyc.size() != 4) begin errors++; $display("FAIL burst_valid_count got %0d want 4", q_vcyc.size()); end
    else for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_d;
      exp_d = cnt_at(2'(k), c0 + int'(k * P + TA));
      checks++;
      if (q_vcyc[k] != k * P + VOFF || q_idx[k] !== 2'(k) || q_data[k] !== exp_d) begin
        errors++; $display("FAIL burst_word%0d got c%0d idx %0d data %h want c%0d idx %0d data %h",
                           k, q_vcyc[k], q_idx[k], q_data[k], k * P + VOFF, k, exp_d); end
    end
    checks++;
    if (q_dcyc.size() != 1 || q_dcyc[0] != 4 * P + 1 || busy_lo != 4 * P + 1) begin
      errors++; $display("FAIL burst_done got %0d dones busy_lo %0d want 1 at %0d", q_dcyc.size(), busy_lo, 4 * P + 1); end
    checks++; if (viol != 0) begin errors++; $display("FAIL burst_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_start_ignored();
    int nv, nd, dc;
    int ev[$], ed[$], gv[$], gd[$];
    kick(1'b0, 2'd1);
    nv = 0; nd = 0; dc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (hif.valid) nv++;
      if (hif.done) begin nd++; dc = c; end
      hif.start = (c >= 2 && c <= 6);
    end
    checks++;
    if (nv != 1 || nd != 1 || dc != P + 1) begin
      errors++; $display("FAIL busy_start got %0d valids %0d dones at %0d want 1 1 at %0d", nv, nd, dc, P + 1); end
    // Start held high: a new transaction begins on the idle cycle after each done.
    for (int e = 0; e < 20; e += P + 1) begin ev.push_back(e + VOFF); ed.push_back(e + P + 1); end
    @(negedge clk);
    hif.start = 1'b1; hif.burst = 1'b0; hif.addr = 2'd3;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hif.valid) gv.push_back(c);
      if (hif.done) gd.push_back(c);
      if (c == 20) hif.start = 1'b0;
    end
    checks++;
    if (gv != ev || gd != ed) begin
      errors++; $display("FAIL held_start got %0d valids %0d dones want %0d %0d", gv.size(), gd.size(), ev.size(), ed.size()); end
  endtask

  task automatic test_reset_mid();
    int hit, nv, nd;
    kick(1'b0, 2'd1);
    hit = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!rd) begin hit = c; break; end
    end
    checks++; if (hit != TA + TH + 2) begin errors++; $display("FAIL mid_rd_fall got %0d want %0d", hit, TA + TH + 2); end
    rst = 1'b0;
    #1;
    checks++; if (ale !== 1'b0 || rd !== 1'b1 || dut.ad_oe_q !== 1'b0) begin
      errors++; $display("FAIL mid_bus_release got ale %b rd %b drive %b want 0 1 0", ale, rd, dut.ad_oe_q); end
    checks++; if (hif.busy !== 1'b0 || hif.valid !== 1'b0 || hif.done !== 1'b0) begin
      errors++; $display("FAIL mid_strobes got %b%b%b want 000", hif.busy, hif.valid, hif.done); end
    @(negedge clk);
    rst = 1'b1;
    nv = 0; nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (hif.valid) nv++;
      if (hif.done) nd++;
    end
    checks++; if (nv != 0 || nd != 0 || hif.data !== 8'h00) begin
      errors++; $display("FAIL mid_no_result got %0d valids %0d dones data %h want 0 0 00", nv, nd, hif.data); end
    for (int i = 0; i < 4; i++) inc[i] = 8'd0;
    base[1] = 8'h3C;
    kick(1'b0, 2'd1);
    collect(12);
    checks++;
    if (q_vcyc.size() != 1 || q_vcyc[0] != VOFF || q_data[0] !== 8'h3C || q_idx[0] !== 2'd1 ||
        q_dcyc.size() != 1 || q_dcyc[0] != P + 1) begin
      errors++; $display("FAIL mid_recover got %0d valids %0d dones data %h want 1 1 data 3c",
                         q_vcyc.size(), q_dcyc.size(), (q_data.size() > 0) ? q_data[0] : 8'h00); end
  endtask

  task automatic test_min_timing();
    int gv[$], gd[$], nale;
    logic [1:0] gi[$];
    logic [7:0] gdat[$];
    nale = 0;
    @(negedge clk);
    hif2.start = 1'b1; hif2.burst = 1'b1; hif2.addr = 2'd2;
    @(posedge clk);
    #1;
    hif2.start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (hif2.valid) begin gv.push_back(c); gi.push_back(hif2.idx); gdat.push_back(hif2.data); end
      if (hif2.done) gd.push_back(c);
      if (ale2) nale++;
    end
    checks++;
    if (gv.size() != 4) begin errors++; $display("FAIL min_valid_count got %0d want 4", gv.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (gv[k] != (k + 1) * P2 || gi[k] !== 2'(k) || gdat[k] !== (8'hC0 | 8'(k))) begin
        errors++; $display("FAIL min_word%0d got c%0d idx %0d data %h want c%0d idx %0d", k, gv[k], gi[k], gdat[k], (k + 1) * P2, k); end
    end
    checks++;
    if (gd.size() != 1 || gd[0] != 4 * P2 + 1 || nale != 4 || wr2 !== 1'b1) begin
      errors++; $display("FAIL min_done got %0d dones ale %0d want 1 at %0d ale 4", gd.size(), nale, 4 * P2 + 1); end
  endtask

  task automatic test_random_protocol();
    for (int t = 0; t < 1000; t++) begin
      logic       b;
      logic [1:0] a;
      int         nw, bad;
      b = 1'($urandom); a = 2'($urandom);
      nw = b ? 4 : 1;
      kick(b, a);
      collect(nw * P + 2);
      bad = 0;
      if (q_vcyc.size() != nw || q_dcyc.size() != 1) bad++;
      else begin
        for (int k = 0; k < nw; k++) begin
          logic [1:0] ei;
          ei = b ? 2'(k) : a;
          if (q_vcyc[k] != k * P + VOFF || q_idx[k] !== ei ||
              q_data[k] !== cnt_at(ei, c0 + int'(k * P + TA))) bad++;
        end
        if (q_dcyc[0] != nw * P + 1) bad++;
      end
      if (viol != 0) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL random_txn%0d burst %b addr %0d got %0d valids %0d dones %0d violations %0d bad want 0 bad",
                           t, b, a, q_vcyc.size(), q_dcyc.size(), viol, bad); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    hif.start = 1'b0; hif.burst = 1'b0; hif.addr = 2'd0;
    hif2.start = 1'b0; hif2.burst = 1'b0; hif2.addr = 2'd0;
    for (int i = 0; i < 4; i++) begin base[i] = 8'd0; inc[i] = 8'd0; end
    test_reset();
    test_single();
    test_burst();
    test_start_ignored();
    test_reset_mid();
    test_min_timing();
    test_random_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
